project_select_sequencer: RTL and testbench



---
 rtl/project_select_pkg.sv | 26 ++
 rtl/sel_debounce.sv | 61 ++++++
 rtl/project_select_sequencer.sv | 130 +++++++++++++
 tb/tb_project_select_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_select_pkg.sv
// ============================================================================
// Module   : project_select_pkg
// Purpose  : Shared widths, defaults and FSM encoding for project selection.
// Revision : 1.0
// ============================================================================
`default_nettype none

package project_select_pkg;

    localparam int c_SEL_BITS      = 5;
    localparam int c_NUM_PROJ      = 20;
    localparam int c_INPUT_BITS    = 8;
    localparam int c_OUTPUT_BITS   = 8;
    localparam int c_SYNC_STAGES   = 2;
    localparam int c_STABLE_CYCLES = 4;
    localparam int c_RESET_CYCLES  = 8;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        RESET  = 2'd1,
        RUN    = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/sel_debounce.sv
// ============================================================================
// Module   : sel_debounce
// Purpose  : Synchronises the raw select pins and reports when they hold still.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sel_debounce
    import project_select_pkg::*;
#(
    parameter int SEL_BITS      = c_SEL_BITS,
    parameter int SYNC_STAGES   = c_SYNC_STAGES,
    parameter int STABLE_CYCLES = c_STABLE_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEL_BITS-1:0] i_sel,
    output logic [SEL_BITS-1:0] o_cand,
    output logic                o_stable
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][SEL_BITS-1:0] sync_q, sync_d;
    logic [SEL_BITS-1:0]                  cand_q, cand_d;
    logic [CNT_W-1:0]                     stab_cnt_q, stab_cnt_d;
    logic [SEL_BITS-1:0]                  w_sel_s;

    assign w_sel_s = sync_q[SYNC_STAGES-1];

    always_comb begin : p_next
        sync_d     = {sync_q[SYNC_STAGES-2:0], i_sel};
        cand_d     = cand_q;
        stab_cnt_d = stab_cnt_q;
        // Any disagreement restarts the hold-time measurement from zero.
        if (w_sel_s != cand_q) begin
            cand_d     = w_sel_s;
            stab_cnt_d = '0;
        end else if (stab_cnt_q != CNT_W'(STABLE_CYCLES)) begin
            stab_cnt_d = stab_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            sync_q     <= '0;
            cand_q     <= '0;
            stab_cnt_q <= '0;
        end else begin
            sync_q     <= sync_d;
            cand_q     <= cand_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    assign o_cand   = cand_q;
    assign o_stable = (stab_cnt_q == CNT_W'(STABLE_CYCLES));

endmodule

`default_nettype wire

// File: rtl/project_select_sequencer.sv
// ============================================================================
// Module   : project_select_sequencer
// Purpose  : Debounced project select, per-project reset sequencing, I/O muxing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module project_select_sequencer
    import project_select_pkg::*;
#(
    parameter int SEL_BITS      = c_SEL_BITS,
    parameter int NUM_PROJ      = c_NUM_PROJ,
    parameter int INPUT_BITS    = c_INPUT_BITS,
    parameter int OUTPUT_BITS   = c_OUTPUT_BITS,
    parameter int SYNC_STAGES   = c_SYNC_STAGES,
    parameter int STABLE_CYCLES = c_STABLE_CYCLES,
    parameter int RESET_CYCLES  = c_RESET_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [SEL_BITS-1:0]             sel,
    input  logic [INPUT_BITS-1:0]           in,
    output logic [OUTPUT_BITS-1:0]          out,
    input  logic [NUM_PROJ*OUTPUT_BITS-1:0] proj_out,
    output logic [INPUT_BITS-1:0]           proj_in,
    output logic [NUM_PROJ-1:0]             proj_ena,
    output logic [NUM_PROJ-1:0]             proj_rst_n,
    output logic [SEL_BITS-1:0]             active_sel,
    output logic                            running
);

    localparam int                RST_W      = $clog2(RESET_CYCLES + 1);
    localparam logic [SEL_BITS:0] NUM_PROJ_W = (SEL_BITS + 1)'(NUM_PROJ);

    state_e                 state_q, state_d;
    logic [SEL_BITS-1:0]    active_sel_q, active_sel_d;
    logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic [OUTPUT_BITS-1:0] out_q, out_d;
    logic [SEL_BITS-1:0]    w_cand;
    logic                   w_stable;
    logic [OUTPUT_BITS-1:0] w_proj_slice;

    sel_debounce #(
        .SEL_BITS      (SEL_BITS),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sel_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sel    (sel),
        .o_cand   (w_cand),
        .o_stable (w_stable)
    );

    always_comb begin : p_slice
        w_proj_slice = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            if (active_sel_q == SEL_BITS'(k)) begin
                w_proj_slice = proj_out[k*OUTPUT_BITS +: OUTPUT_BITS];
            end
        end
    end

    always_comb begin : p_fsm
        state_d      = state_q;
        active_sel_d = active_sel_q;
        rst_cnt_d    = rst_cnt_q;
        out_d        = '0;
        case (state_q)
            SETTLE: begin
                // Out-of-range selects park here with nothing enabled.
                if (w_stable && ({1'b0, w_cand} < NUM_PROJ_W)) begin
                    active_sel_d = w_cand;
                    rst_cnt_d    = '0;
                    state_d      = RESET;
                end
            end
            RESET: begin
                if (w_cand != active_sel_q) begin
                    state_d = SETTLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                    if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                out_d = w_proj_slice;
                if (w_cand != active_sel_q) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            state_q      <= SETTLE;
            active_sel_q <= '0;
            rst_cnt_q    <= '0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            rst_cnt_q    <= rst_cnt_d;
            out_q        <= out_d;
        end
    end

    always_comb begin : p_decode
        proj_ena   = '0;
        proj_rst_n = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            if (active_sel_q == SEL_BITS'(k)) begin
                proj_ena[k]   = (state_q == RESET) || (state_q == RUN);
                proj_rst_n[k] = (state_q == RUN);
            end
        end
    end

    assign running    = (state_q == RUN);
    assign proj_in    = in & {INPUT_BITS{running}};
    assign out        = out_q;
    assign active_sel = active_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_project_select_sequencer.sv
// ============================================================================
// Module   : tb_project_select_sequencer
// Purpose  : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_project_select_sequencer;

    localparam int NP = 20;
    localparam int SB = 5;
    localparam int IB = 8;
    localparam int OB = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [SB-1:0]  sel = '0;
    logic [IB-1:0]  in_bus = '0;
    logic [OB-1:0]  out;
    logic [NP*OB-1:0] proj_out = '0;
    logic [IB-1:0]  proj_in;
    logic [NP-1:0]  proj_ena;
    logic [NP-1:0]  proj_rst_n;
    logic [SB-1:0]  active_sel;
    logic           running;

    always #5 clk = ~clk;

    project_select_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .in         (in_bus),
        .out        (out),
        .proj_out   (proj_out),
        .proj_in    (proj_in),
        .proj_ena   (proj_ena),
        .proj_rst_n (proj_rst_n),
        .active_sel (active_sel),
        .running    (running)
    );

    int total = 0;
    int bad   = 0;

    // Reference: sel history seen at each edge, and one "owner" project with
    // the number of edges since it was first enabled.
    int         hist[7];
    int         edges;
    int         m_cand;
    bit         m_stable;
    int         m_proj;
    int         m_since;
    int         m_last;
    logic [OB-1:0] m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 7; i++) hist[i] = 0;
        edges    = 0;
        m_cand   = 0;
        m_stable = 1'b0;
        m_proj   = -1;
        m_since  = 0;
        m_last   = 0;
        m_out    = '0;
    endfunction

    function automatic bit model_running();
        return (m_proj >= 0) && (m_since >= 8);
    endfunction

    task automatic model_step();
        m_out = '0;
        if (model_running()) m_out = proj_out[m_proj*OB +: OB];
        if (m_proj < 0) begin
            if (m_stable && m_cand < NP) begin
                m_proj  = m_cand;
                m_last  = m_cand;
                m_since = 0;
            end
        end else if (m_cand != m_proj) begin
            m_proj = -1;
        end else if (m_since < 1000) begin
            m_since++;
        end
        for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(sel);
        edges++;
        m_cand   = hist[2];
        m_stable = (edges >= 4) && (hist[2] == hist[3]) && (hist[3] == hist[4])
                   && (hist[4] == hist[5]) && (hist[5] == hist[6]);
    endtask

    task automatic check_model();
        logic [NP-1:0] e_ena;
        logic [NP-1:0] e_rst;
        e_ena = '0;
        e_rst = '0;
        if (m_proj >= 0) e_ena[m_proj] = 1'b1;
        if (model_running()) e_rst = e_ena;
        chk("m_running", 32'(running), 32'(model_running()));
        chk("m_active", 32'(active_sel), 32'(m_last));
        chk("m_ena", 32'(proj_ena), 32'(e_ena));
        chk("m_rst_n", 32'(proj_rst_n), 32'(e_rst));
        chk("m_proj_in", 32'(proj_in), model_running() ? 32'(in_bus) : 32'd0);
        chk("m_out", 32'(out), 32'(m_out));
    endtask

    task automatic drive_data();
        in_bus = IB'($urandom);
        for (int i = 0; i < NP*OB/32; i++) proj_out[i*32 +: 32] = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_data();
            tick();
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_running"}, 32'(running), 32'd0);
        chk({tag, "_ena"}, 32'(proj_ena), 32'd0);
        chk({tag, "_rst_n"}, 32'(proj_rst_n), 32'd0);
        chk({tag, "_out"}, 32'(out), 32'd0);
        chk({tag, "_proj_in"}, 32'(proj_in), 32'd0);
        chk({tag, "_active"}, 32'(active_sel), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [SB-1:0] sel;
        int            hold;
        logic          exp_run;
        logic [SB-1:0] exp_act;
        logic [NP-1:0] exp_ena;
        logic [NP-1:0] exp_rstn;
    } vec_t;

    initial begin
        vec_t vecs[8];
        bit   saw5, saw_drop, found, saw_rst6;
        int   rst_cycles;

        vecs[0] = '{5'd3,  4,  1'b0, 5'd0,  20'h00000, 20'h00000};
        vecs[1] = '{5'd3,  12, 1'b1, 5'd3,  20'h00008, 20'h00008};
        vecs[2] = '{5'd25, 30, 1'b0, 5'd3,  20'h00000, 20'h00000};
        vecs[3] = '{5'd2,  16, 1'b1, 5'd2,  20'h00004, 20'h00004};
        vecs[4] = '{5'd19, 16, 1'b1, 5'd19, 20'h80000, 20'h80000};
        vecs[5] = '{5'd20, 30, 1'b0, 5'd19, 20'h00000, 20'h00000};
        vecs[6] = '{5'd0,  15, 1'b0, 5'd0,  20'h00001, 20'h00000};
        vecs[7] = '{5'd0,  1,  1'b1, 5'd0,  20'h00001, 20'h00001};

        // Power-up with sel=0: RUN lands on the 13th edge after release.
        model_reset();
        drive_data();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_ena", 32'(proj_ena), 32'd0);
        chk("reset_rst_n", 32'(proj_rst_n), 32'd0);
        chk("reset_out", 32'(out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(12);
        chk("boot_pre_run", 32'(running), 32'd0);
        run(1);
        chk("boot_run", 32'(running), 32'd1);
        chk("boot_rst_n", 32'(proj_rst_n), 32'd1);
        chk("boot_ena", 32'(proj_ena), 32'd1);

        for (int v = 0; v < 8; v++) begin
            sel = vecs[v].sel;
            run(vecs[v].hold);
            chk($sformatf("vec%0d_running", v), 32'(running), 32'(vecs[v].exp_run));
            chk($sformatf("vec%0d_active", v), 32'(active_sel), 32'(vecs[v].exp_act));
            chk($sformatf("vec%0d_ena", v), 32'(proj_ena), 32'(vecs[v].exp_ena));
            chk($sformatf("vec%0d_rst_n", v), 32'(proj_rst_n), 32'(vecs[v].exp_rstn));
        end

        // Two-cycle glitch 3->5->3 while running project 3.
        sel = 5'd3;
        run(16);
        chk("glitch_pre_run", 32'(running), 32'd1);
        sel = 5'd5;
        run(2);
        sel = 5'd3;
        saw5 = 1'b0;
        saw_drop = 1'b0;
        rst_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            run(1);
            if (proj_ena[5]) saw5 = 1'b1;
            if (!running) saw_drop = 1'b1;
            if (proj_ena[3] && !proj_rst_n[3]) rst_cycles++;
        end
        chk("glitch_never_5", 32'(saw5), 32'd0);
        chk("glitch_dropped", 32'(saw_drop), 32'd1);
        chk("glitch_reset_len", 32'(rst_cycles), 32'd8);
        chk("glitch_rerun", 32'(running), 32'd1);
        chk("glitch_active", 32'(active_sel), 32'd3);

        // Select changes on the third cycle of project 6's reset.
        sel = 5'd6;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            run(1);
            if (proj_ena[6]) found = 1'b1;
        end
        chk("abort_wait_reset", 32'(found), 32'd1);
        run(3);
        sel = 5'd7;
        saw_rst6 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            run(1);
            if (proj_rst_n[6]) saw_rst6 = 1'b1;
        end
        chk("abort_no_rst6", 32'(saw_rst6), 32'd0);
        chk("abort_run7", 32'(running), 32'd1);
        chk("abort_active", 32'(active_sel), 32'd7);

        // Asynchronous reset in the middle of RUN.
        sel = 5'd0;
        run(20);
        chk("areset_pre_run", 32'(running), 32'd1);
        async_reset("areset");
        run(12);
        chk("areset_pre", 32'(running), 32'd0);
        run(1);
        chk("areset_run", 32'(running), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                sel = ($urandom_range(0, 3) == 0) ? SB'($urandom_range(0, 31))
                                                  : SB'($urandom_range(0, NP-1));
            end
            if (i == 1500) async_reset("rand_reset");
            run(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
